// File: rtl/circle_frame_reader_pkg.sv
// Shared definitions for the circle frame reader: FSM encoding, word geometry,
// the plot_circle broadcast id and a small pixel packing helper.
package circle_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PIX_PER_WORD = 32;

  // Broadcast id of the plot_circle slave, kept for a future clear master.
  localparam logic [5:0] CMD_ID_ALL = 6'h0;

  // Return word with bit pos replaced by pix.
  function automatic logic [31:0] pack_bit(input logic [31:0] word,
                                           input logic [4:0]  pos,
                                           input logic        pix);
    logic [31:0] res;
    res      = word;
    res[pos] = pix;
    return res;
  endfunction

endpackage

// File: rtl/circle_frame_reader_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. A push into a full FIFO is
// only taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & (r_count != {(AW+1){1'b0}});
  assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

  assign o_valid = (r_count != {(AW+1){1'b0}});
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
  assign o_count = r_count;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/circle_frame_reader.sv
// Avalon-MM read master sweeping every pixel address of the plot_circle slave,
// packing the 1-bit responses into 32-bit words streamed out via valid/ready.
module circle_frame_reader
  import circle_frame_reader_pkg::*;
#(
  parameter int DATAW      = 18,
  parameter int MAX_OUT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             avm_read,
  output logic [DATAW-1:0] avm_address,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic [31:0]      st_data,
  output logic             st_valid,
  input  logic             st_ready,
  output logic             st_last
);

  localparam int              CW        = $clog2(FIFO_DEPTH*PIX_PER_WORD) + 1;
  localparam int              FAW       = $clog2(FIFO_DEPTH);
  localparam logic [DATAW:0]  TOTAL     = {1'b1, {DATAW{1'b0}}};
  localparam logic [DATAW:0]  LAST_IDX  = {1'b0, {DATAW{1'b1}}};
  localparam logic [CW-1:0]   CRED_FULL = CW'(FIFO_DEPTH*PIX_PER_WORD);
  localparam logic [CW-1:0]   CRED_WORD = CW'(PIX_PER_WORD);
  localparam logic [3:0]      MAX_OUT_L = 4'(MAX_OUT);

  state_t          r_state, w_state_nxt;
  logic [DATAW:0]  r_issue_addr, w_issue_nxt;
  logic [DATAW:0]  r_rsp_cnt, w_rsp_nxt;
  logic [3:0]      r_outst, w_outst_nxt;
  logic [CW-1:0]   r_credits, w_credits_nxt;
  logic [31:0]     r_pack, w_pack_nxt, w_word;
  logic            r_avm_read, r_busy, r_done, w_read_nxt;
  logic            w_accept, w_rsp, w_push, w_pop, w_last_word;
  logic [32:0]     w_fifo_out;
  logic            w_fifo_valid;
  logic [FAW:0]    w_fifo_count, w_fifo_after;

  // Handshakes, counter updates and FSM next state.
  always_comb begin
    w_accept      = r_avm_read & ~avm_waitrequest;
    // Responses with nothing in flight (spurious or from before a reset) are dropped.
    w_rsp         = avm_readdatavalid & (r_outst != 4'd0);
    w_pop         = w_fifo_valid & st_ready;
    w_word        = pack_bit(r_pack, r_rsp_cnt[4:0], avm_readdata[r_rsp_cnt[2:0]]);
    w_push        = w_rsp & (r_rsp_cnt[4:0] == 5'd31);
    w_last_word   = (r_rsp_cnt == LAST_IDX);
    w_fifo_after  = w_fifo_count + {{FAW{1'b0}}, w_push} - {{FAW{1'b0}}, w_pop};
    w_issue_nxt   = r_issue_addr + {{DATAW{1'b0}}, w_accept};
    w_rsp_nxt     = r_rsp_cnt + {{DATAW{1'b0}}, w_rsp};
    w_pack_nxt    = w_rsp ? (w_push ? 32'd0 : w_word) : r_pack;
    // Credits count free FIFO pixel slots not yet claimed by an issued read.
    w_credits_nxt = r_credits - {{(CW-1){1'b0}}, w_accept} + (w_pop ? CRED_WORD : {CW{1'b0}});
    if (w_accept && !w_rsp) begin
      w_outst_nxt = r_outst + 4'd1;
    end else if (!w_accept && w_rsp) begin
      w_outst_nxt = r_outst - 4'd1;
    end else begin
      w_outst_nxt = r_outst;
    end
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_ISSUE;
          w_issue_nxt   = {(DATAW+1){1'b0}};
          w_rsp_nxt     = {(DATAW+1){1'b0}};
          w_outst_nxt   = 4'd0;
          w_credits_nxt = CRED_FULL;
          w_pack_nxt    = 32'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_accept && (r_issue_addr == LAST_IDX)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if ((w_rsp_nxt == TOTAL) && (w_fifo_after == {(FAW+1){1'b0}})) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Depends only on next-state values, so a stalled request stays asserted.
    w_read_nxt = (w_state_nxt == ST_ISSUE) && (w_outst_nxt < MAX_OUT_L) &&
                 (w_credits_nxt != {CW{1'b0}});
  end

  // State, counters, packer and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_issue_addr <= {(DATAW+1){1'b0}};
      r_rsp_cnt    <= {(DATAW+1){1'b0}};
      r_outst      <= 4'd0;
      r_credits    <= CRED_FULL;
      r_pack       <= 32'd0;
      r_avm_read   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_issue_addr <= w_issue_nxt;
      r_rsp_cnt    <= w_rsp_nxt;
      r_outst      <= w_outst_nxt;
      r_credits    <= w_credits_nxt;
      r_pack       <= w_pack_nxt;
      r_avm_read   <= w_read_nxt;
      r_busy       <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  ({w_last_word, w_word}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign avm_read    = r_avm_read;
  assign avm_address = r_issue_addr[DATAW-1:0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign st_valid    = w_fifo_valid;
  assign st_data     = w_fifo_out[31:0];
  assign st_last     = w_fifo_out[32];

endmodule

// File: tb/tb_circle_frame_reader.sv
// Self-checking bench for circle_frame_reader: bitmap slave with configurable
// waitrequest and latency, frame-level word model and per-cycle scoreboard.
module tb_circle_frame_reader;

  localparam int DATAW      = 7;
  localparam int MAX_OUT    = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int NPIX       = 128;
  localparam int NWORD      = NPIX / 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, avm_read;
  logic [DATAW-1:0] avm_address;
  logic             avm_waitrequest = 1'b0;
  logic [31:0]      avm_readdata = 32'd0;
  logic             avm_readdatavalid = 1'b0;
  logic [31:0]      st_data;
  logic             st_valid, st_last;
  logic             st_ready = 1'b0;

  always #5 clk = ~clk;

  circle_frame_reader #(
    .DATAW (DATAW), .MAX_OUT (MAX_OUT), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .busy (busy), .done (done),
    .avm_read (avm_read), .avm_address (avm_address),
    .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data (st_data), .st_valid (st_valid), .st_ready (st_ready), .st_last (st_last)
  );

  int n_cmp = 0, n_bad = 0;
  int pat_sel = 0, wait_pct = 0, lat_max = 1;
  bit spur = 1'b0;
  int cyc = 0, sc = 0, first_valid = -1;
  int accepts = 0, outst = 0, widx = 0, done_cnt = 0, last_pop_cyc = -100;
  logic [DATAW-1:0] sq_addr[$];
  int               sq_due[$];
  bit               hold_pend = 1'b0;
  logic [DATAW-1:0] hold_addr = '0;
  logic [31:0]      exp_word [NWORD];

  function automatic bit pix(input int a);
    case (pat_sel)
      0:       return (a % 3) == 0;
      default: return (a % 5) == 1;
    endcase
  endfunction

  // Expected frame contents straight from the bitmap: pixel k of word w at bit k.
  task automatic build_model(input int p);
    pat_sel = p;
    for (int w = 0; w < NWORD; w++) begin
      exp_word[w] = 32'd0;
      for (int k = 0; k < 32; k++) exp_word[w][k] = pix(32*w + k);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave model plus the single per-cycle compare process.
  always @(negedge clk) begin
    bit acc, rsp;
    logic [31:0] d;
    cyc++;
    if (reset) begin outst = 0; hold_pend = 1'b0; end
    avm_waitrequest = (wait_pct > 0) ? ($urandom_range(99) < wait_pct) : 1'b0;
    if (spur) begin
      avm_readdatavalid = 1'b1; avm_readdata = 32'hFFFF_FFFF;
    end else if (sq_due.size() > 0 && sq_due[0] <= cyc) begin
      d = 32'd0;
      d[sq_addr[0][2:0]] = pix(int'(sq_addr[0]));
      avm_readdatavalid = 1'b1; avm_readdata = d;
      void'(sq_addr.pop_front()); void'(sq_due.pop_front());
    end else begin
      avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    end
    if (!reset) begin
      if (done) begin
        done_cnt++;
        chk("done_after_last_pop", cyc - last_pop_cyc, 1);
        chk("done_word_count", widx, NWORD);
      end
      acc = avm_read && !avm_waitrequest;
      if (hold_pend) chk("hold_under_wait", {avm_read, avm_address}, {1'b1, hold_addr});
      hold_pend = avm_read && avm_waitrequest;
      hold_addr = avm_address;
      if (acc) begin
        chk("accept_addr", avm_address, accepts % NPIX);
        accepts++;
        sq_addr.push_back(avm_address);
        sq_due.push_back(cyc + $urandom_range(lat_max, 1));
      end
      rsp = avm_readdatavalid && (outst > 0);
      outst = outst + int'(acc) - int'(rsp);
      if (acc) chk("outstanding_max", outst <= MAX_OUT, 1);
      if (st_valid && first_valid < 0) first_valid = cyc;
      if (st_valid && st_ready) begin
        chk("word_in_range", widx < NWORD, 1);
        chk("st_word", {st_last, st_data}, {(widx == NWORD-1), exp_word[widx % NWORD]});
        widx++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1; sc = cyc; widx = 0; accepts = 0; first_valid = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    chk("done_seen", done_cnt - d0, 1);
    repeat (6) @(posedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("frame_words", widx, NWORD);
    chk("idle_after_frame", {busy, avm_read, st_valid}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    build_model(1);
    chk("model_pat1_w0", exp_word[0], 32'h8421_0842);
    build_model(0);
    chk("model_pat0_w0", exp_word[0], 32'h4924_9249);
    chk("model_pat0_w1", exp_word[1], 32'h9249_2492);
    chk("model_pat0_w2", exp_word[2], 32'h2492_4924);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, avm_read, avm_address, st_valid, st_last, st_data}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: plain frame, downstream always ready
    st_ready = 1'b1;
    pulse_start();
    wait_done(2000);
    chk("first_word_latency", (first_valid - sc) >= 33, 1);

    // 2: backpressure limits reads to FIFO capacity
    st_ready = 1'b0;
    pulse_start();
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("bp_accepts", accepts, FIFO_DEPTH*32);
    chk("bp_read_low", {avm_read, busy, st_valid}, 3'b011);
    @(posedge clk); #1 st_ready = 1'b1;
    wait_done(2000);

    // 3: random waitrequest and variable latency
    wait_pct = 50; lat_max = 3;
    pulse_start();
    wait_done(4000);
    wait_pct = 0; lat_max = 1;

    // 4: reset mid-frame, then a clean frame with another bitmap
    pulse_start();
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("midreset_outputs", {busy, done, avm_read, avm_address, st_valid, st_last, st_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_no_word", widx, 0);
    build_model(1);
    pulse_start();
    wait_done(2000);

    // 5: second start mid-frame is ignored
    build_model(0);
    pulse_start();
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2000);
    chk("restart_accepts", accepts, NPIX);

    // 6: spurious readdatavalid while idle
    @(posedge clk); #1 spur = 1'b1;
    repeat (3) begin @(negedge clk); chk("spur_no_valid", st_valid, 1'b0); end
    @(posedge clk); #1 spur = 1'b0;
    repeat (4) begin @(negedge clk); chk("spur_idle", {st_valid, busy}, 2'b00); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
